// File: rtl/sudoku_pkg.sv
// Shared screen encodings and VGA timing constants for the sudoku display path.
package sudoku_pkg;

  typedef enum logic [1:0] {
    SMENU = 2'd0,
    SGAME = 2'd1,
    SOVER = 2'd2
  } screen_state_t;

  localparam int unsigned V_ACTIVE = 480;

endpackage

// File: rtl/screen_state_ctrl_if.sv
// Bundle of VGA position, mouse/link status and screen-control outputs.
interface screen_state_ctrl_if;
  import sudoku_pkg::*;

  logic [9:0]    h_cnt;
  logic [9:0]    v_cnt;
  logic          MOUSE_LEFT;
  logic          mouse_on_start_button;
  logic          mouse_on_connect_button;
  logic          mouse_on_return_button;
  logic          connected;
  logic          board_solved;
  screen_state_t state;
  logic          game_start;
  logic          connect_req;

  modport master (
    output h_cnt, v_cnt, MOUSE_LEFT, mouse_on_start_button,
           mouse_on_connect_button, mouse_on_return_button,
           connected, board_solved,
    input  state, game_start, connect_req
  );

  modport slave (
    input  h_cnt, v_cnt, MOUSE_LEFT, mouse_on_start_button,
           mouse_on_connect_button, mouse_on_return_button,
           connected, board_solved,
    output state, game_start, connect_req
  );

endinterface

// File: rtl/screen_state_ctrl_click.sv
// Rising-edge detector for the mouse button: one-cycle click per press.
module click_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic click_o
);

  logic btn_q;

  always_ff @(posedge clk) begin
    if (rst) btn_q <= 1'b0;
    else     btn_q <= btn_i;
  end

  assign click_o = btn_i & ~btn_q;

endmodule

// File: rtl/screen_state_ctrl.sv
// Screen sequencer: requests are held pending and committed at the start of vblank.
// Optional OVER_AUTO_RETURN_EN: leave the game-over screen after OVER_FRAMES frames.
module screen_state_ctrl #(
  parameter int unsigned V_ACTIVE    = sudoku_pkg::V_ACTIVE,
  parameter int unsigned OVER_FRAMES = 600
) (
  input logic          clk,
  input logic          rst,
  screen_state_ctrl_if.slave bus
);
  import sudoku_pkg::*;

  localparam logic [9:0] BOUND_V = 10'(V_ACTIVE);

  screen_state_t state_q, state_d, pend_state_q, pend_state_d, req_state;
  logic pend_vld_q, pend_vld_d, game_start_q, game_start_d;
  logic connect_req_q, connect_req_d;
  logic click, boundary, req_vld, illegal;

  click_edge_det u_click (
    .clk     (clk),
    .rst     (rst),
    .btn_i   (bus.MOUSE_LEFT),
    .click_o (click)
  );

  assign boundary = (bus.v_cnt == BOUND_V) && (bus.h_cnt == '0);

`ifdef OVER_AUTO_RETURN_EN
  localparam int unsigned CW = $clog2(OVER_FRAMES + 1);
  localparam logic [CW-1:0] OVER_LAST = CW'(OVER_FRAMES);
  logic [CW-1:0] over_cnt_q, over_cnt_d;
  logic          over_done;

  assign over_done = (over_cnt_q == OVER_LAST);

  always_comb begin
    over_cnt_d = over_cnt_q;
    if (pend_vld_q && boundary && pend_state_q == SOVER)
      over_cnt_d = '0;
    else if (state_q == SOVER && boundary && !over_done)
      over_cnt_d = over_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) over_cnt_q <= '0;
    else     over_cnt_q <= over_cnt_d;
  end
`endif

  // Request decode from the committed screen; start beats connect on a shared click.
  always_comb begin
    req_vld       = 1'b0;
    req_state     = SMENU;
    connect_req_d = 1'b0;
    illegal       = 1'b0;
    case (state_q)
      SMENU: begin
        if (click && bus.mouse_on_start_button) begin
          if (bus.connected) begin
            req_vld   = 1'b1;
            req_state = SGAME;
          end
        end else if (click && bus.mouse_on_connect_button) begin
          connect_req_d = 1'b1;
        end
      end
      SGAME: begin
        if (bus.board_solved) begin
          req_vld   = 1'b1;
          req_state = SOVER;
        end else if (!bus.connected) begin
          req_vld   = 1'b1;
          req_state = SMENU;
        end
      end
      SOVER: begin
        if (click && bus.mouse_on_return_button) begin
          req_vld   = 1'b1;
          req_state = SMENU;
        end
`ifdef OVER_AUTO_RETURN_EN
        else if (over_done) begin
          req_vld   = 1'b1;
          req_state = SMENU;
        end
`endif
      end
      default: illegal = 1'b1;
    endcase
  end

  // A request seen on the boundary edge only loads the pending slot, so it waits a frame.
  always_comb begin
    state_d      = state_q;
    pend_vld_d   = pend_vld_q;
    pend_state_d = pend_state_q;
    game_start_d = 1'b0;
    if (illegal) begin
      state_d    = SMENU;
      pend_vld_d = 1'b0;
    end else if (pend_vld_q) begin
      if (boundary) begin
        state_d      = pend_state_q;
        pend_vld_d   = 1'b0;
        game_start_d = (pend_state_q == SGAME);
      end
    end else if (req_vld) begin
      pend_vld_d   = 1'b1;
      pend_state_d = req_state;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= SMENU;
      pend_vld_q    <= 1'b0;
      pend_state_q  <= SMENU;
      game_start_q  <= 1'b0;
      connect_req_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pend_vld_q    <= pend_vld_d;
      pend_state_q  <= pend_state_d;
      game_start_q  <= game_start_d;
      connect_req_q <= connect_req_d;
    end
  end

  assign bus.state       = state_q;
  assign bus.game_start  = game_start_q;
  assign bus.connect_req = connect_req_q;

endmodule

// File: tb/tb_screen_state_ctrl.sv
// Directed bench for screen_state_ctrl using a compressed VGA raster (2 columns per line).
module tb_screen_state_ctrl;
  import sudoku_pkg::*;

  localparam int unsigned H_TOTAL   = 2;
  localparam int unsigned V_TOTAL   = 482;
  localparam int unsigned FRAME_CYC = H_TOTAL * V_TOTAL;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   fails  = 0;
  int   gs_cnt = 0;
  int   cr_cnt = 0;
  int   consec = 0;

  screen_state_ctrl_if bus ();

  screen_state_ctrl #(.V_ACTIVE(480), .OVER_FRAMES(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          on_start;
    logic          on_conn;
    logic          linked;
    logic          exp_cr;
    screen_state_t exp_st;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step_neg();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_mouse();
    bus.MOUSE_LEFT              = 1'b0;
    bus.mouse_on_start_button   = 1'b0;
    bus.mouse_on_connect_button = 1'b0;
    bus.mouse_on_return_button  = 1'b0;
  endtask

  task automatic do_reset();
    step_neg();
    rst = 1'b1;
    clear_mouse();
    bus.board_solved = 1'b0;
    repeat (2) @(posedge clk);
    step_neg();
    rst = 1'b0;
  endtask

  task automatic wait_line(input int line);
    int n = 0;
    step_neg();
    while (bus.v_cnt != 10'(line)) begin
      step_neg();
      n++;
      if (n > int'(FRAME_CYC) + 8) begin
        chk("wait_line_timeout", 1, 0);
        return;
      end
    end
  endtask

  // Leaves time just before the boundary edge (counters show v=480,h=0).
  task automatic pre_boundary();
    int n = 0;
    step_neg();
    while (!(bus.v_cnt == 10'd480 && bus.h_cnt == 10'd0)) begin
      step_neg();
      n++;
      if (n > int'(FRAME_CYC) + 8) begin
        chk("boundary_timeout", 1, 0);
        return;
      end
    end
  endtask

  task automatic cross_boundary();
    pre_boundary();
    @(posedge clk);
    #1;
  endtask

  task automatic click(input logic s, input logic c, input logic r,
                       output logic cr1, output logic cr2);
    step_neg();
    bus.mouse_on_start_button   = s;
    bus.mouse_on_connect_button = c;
    bus.mouse_on_return_button  = r;
    bus.MOUSE_LEFT              = 1'b1;
    @(posedge clk);
    #1;
    cr1 = bus.connect_req;
    step_neg();
    clear_mouse();
    @(posedge clk);
    #1;
    cr2 = bus.connect_req;
  endtask

  // Raster generator: counters move on the falling edge, away from DUT sampling.
  initial begin
    bus.h_cnt = '0;
    bus.v_cnt = '0;
    forever begin
      @(negedge clk);
      if (bus.h_cnt == 10'(H_TOTAL - 1)) begin
        bus.h_cnt = '0;
        bus.v_cnt = (bus.v_cnt == 10'(V_TOTAL - 1)) ? 10'd0 : bus.v_cnt + 10'd1;
      end else begin
        bus.h_cnt = bus.h_cnt + 10'd1;
      end
    end
  end

  initial begin
    logic gs_p = 1'b0;
    logic cr_p = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.game_start === 1'b1) begin
        gs_cnt++;
        if (gs_p) consec++;
      end
      if (bus.connect_req === 1'b1) begin
        cr_cnt++;
        if (cr_p) consec++;
      end
      gs_p = (bus.game_start === 1'b1);
      cr_p = (bus.connect_req === 1'b1);
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic cr1, cr2;
    int   g0, c0;

    vecs[0] = '{1'b1, 1'b0, 1'b1, 1'b0, SGAME};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0, SMENU};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 1'b1, SMENU};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 1'b0, SGAME};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 1'b1, SMENU};
    vecs[5] = '{1'b0, 1'b0, 1'b1, 1'b0, SMENU};

    clear_mouse();
    bus.connected    = 1'b0;
    bus.board_solved = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    step_neg();
    rst = 1'b0;
    chk("reset_state", 32'(bus.state), 0);
    chk("reset_game_start", 32'(bus.game_start), 0);
    chk("reset_connect_req", 32'(bus.connect_req), 0);

    // Menu click decode table
    for (int i = 0; i < 6; i++) begin
      do_reset();
      bus.connected = vecs[i].linked;
      wait_line(100);
      click(vecs[i].on_start, vecs[i].on_conn, 1'b0, cr1, cr2);
      chk($sformatf("vec%0d_connect_req_t1", i), 32'(cr1), 32'(vecs[i].exp_cr));
      chk($sformatf("vec%0d_connect_req_t2", i), 32'(cr2), 0);
      chk($sformatf("vec%0d_state_pre", i), 32'(bus.state), 0);
      cross_boundary();
      chk($sformatf("vec%0d_state", i), 32'(bus.state), 32'(vecs[i].exp_st));
      chk($sformatf("vec%0d_game_start", i), 32'(bus.game_start),
          32'(vecs[i].exp_st == SGAME));
    end

    // Start path with exact commit cycle
    do_reset();
    bus.connected = 1'b1;
    wait_line(100);
    click(1'b1, 1'b0, 1'b0, cr1, cr2);
    pre_boundary();
    chk("start_state_before_edge", 32'(bus.state), 0);
    @(posedge clk);
    #1;
    chk("start_state_commit", 32'(bus.state), 1);
    chk("start_game_start_pulse", 32'(bus.game_start), 1);
    @(posedge clk);
    #1;
    chk("start_game_start_low", 32'(bus.game_start), 0);

    // Solved and disconnected together: game-over wins
    wait_line(100);
    bus.board_solved = 1'b1;
    bus.connected    = 1'b0;
    step_neg();
    chk("exit_state_pending", 32'(bus.state), 1);
    cross_boundary();
    chk("exit_both_state", 32'(bus.state), 2);
    bus.board_solved = 1'b0;

    // Return click on the boundary cycle waits one frame
    pre_boundary();
    bus.mouse_on_return_button = 1'b1;
    bus.MOUSE_LEFT             = 1'b1;
    @(posedge clk);
    #1;
    chk("ret_on_boundary_not_committed", 32'(bus.state), 2);
    step_neg();
    clear_mouse();
    cross_boundary();
    chk("ret_committed_next_frame", 32'(bus.state), 0);

    // Disconnect only
    do_reset();
    bus.connected = 1'b1;
    wait_line(100);
    click(1'b1, 1'b0, 1'b0, cr1, cr2);
    cross_boundary();
    chk("disc_enter_game", 32'(bus.state), 1);
    wait_line(100);
    bus.connected = 1'b0;
    cross_boundary();
    chk("disc_only_state", 32'(bus.state), 0);

    // Start without link, three frames
    do_reset();
    bus.connected = 1'b0;
    g0 = gs_cnt;
    wait_line(100);
    click(1'b1, 1'b0, 1'b0, cr1, cr2);
    for (int f = 0; f < 3; f++) begin
      cross_boundary();
      chk($sformatf("nolink_state_f%0d", f), 32'(bus.state), 0);
    end
    chk("nolink_game_start_count", gs_cnt - g0, 0);

    // Connect button held for 50 cycles
    wait_line(100);
    c0 = cr_cnt;
    bus.mouse_on_connect_button = 1'b1;
    bus.MOUSE_LEFT              = 1'b1;
    @(posedge clk);
    #1;
    chk("hold_connect_req_t1", 32'(bus.connect_req), 1);
    @(posedge clk);
    #1;
    chk("hold_connect_req_t2", 32'(bus.connect_req), 0);
    repeat (48) @(posedge clk);
    step_neg();
    clear_mouse();
    repeat (2) @(posedge clk);
    #1;
    chk("hold_connect_req_count", cr_cnt - c0, 1);
    chk("hold_state", 32'(bus.state), 0);

    // Reset between click and boundary drops the request
    do_reset();
    bus.connected = 1'b1;
    wait_line(100);
    click(1'b1, 1'b0, 1'b0, cr1, cr2);
    step_neg();
    rst = 1'b1;
    @(posedge clk);
    step_neg();
    rst = 1'b0;
    g0 = gs_cnt;
    cross_boundary();
    chk("rst_mid_state", 32'(bus.state), 0);
    cross_boundary();
    chk("rst_mid_state_next", 32'(bus.state), 0);
    chk("rst_mid_game_start_count", gs_cnt - g0, 0);

    // Game-over dwell
    do_reset();
    bus.connected = 1'b1;
    wait_line(100);
    click(1'b1, 1'b0, 1'b0, cr1, cr2);
    cross_boundary();
    wait_line(100);
    bus.board_solved = 1'b1;
    cross_boundary();
    chk("over_entered", 32'(bus.state), 2);
    bus.board_solved = 1'b0;
`ifdef OVER_AUTO_RETURN_EN
    for (int f = 1; f <= 4; f++) begin
      cross_boundary();
      chk($sformatf("auto_ret_b%0d", f), 32'(bus.state), (f < 4) ? 2 : 0);
    end
`else
    for (int f = 1; f <= 10; f++) begin
      cross_boundary();
      chk($sformatf("over_stay_b%0d", f), 32'(bus.state), 2);
    end
`endif

    chk("pulse_back_to_back", consec, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
